// File: rtl/vga_pkg.sv
// Shared VGA-path types and helpers: raster defaults, scroll settings payload,
// and the modular add used for scroll wrap-around.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned IMG_W_DEF    = 160;
  localparam int unsigned IMG_H_DEF    = 120;
  localparam int unsigned OFS_W        = 8;
  // One bit wider than log2(IMG_W) so col+dx never overflows before the wrap.
  localparam int unsigned SUM_W        = $clog2(IMG_W_DEF) + 1;

  typedef struct packed {
    logic [OFS_W-1:0] dx;
    logic [OFS_W-1:0] dy;
    logic             mirror;
  } scroll_cfg_t;

  // Both operands are below m, so one conditional subtract restores the range.
  function automatic logic [SUM_W-1:0] wrap_add(input logic [SUM_W-1:0] a,
                                                input logic [SUM_W-1:0] b,
                                                input logic [SUM_W-1:0] m);
    logic [SUM_W-1:0] s;
    s = a + b;
    return (s >= m) ? (s - m) : s;
  endfunction

endpackage

// File: rtl/scroll_cfg_reg.sv
// Scroll/mirror settings: validates requests, holds a pending set, and
// promotes it to the active set only at frame_start to avoid tearing.
module scroll_cfg_reg
  import vga_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             req_valid,
  input  logic [OFS_W-1:0] req_dx,
  input  logic [OFS_W-1:0] req_dy,
  input  logic             req_mirror,
  output scroll_cfg_t      active,
  output logic             req_err
);

  scroll_cfg_t active_d, active_q;
  scroll_cfg_t pend_d, pend_q;
  logic        pending_d, pending_q;
  logic        req_err_d, req_err_q;
  logic        req_ok;
  scroll_cfg_t req_cfg;

  always_comb begin
    req_cfg   = '{dx: req_dx, dy: req_dy, mirror: req_mirror};
    req_ok    = req_valid &&
                ({1'b0, req_dx} < (OFS_W+1)'(IMG_W)) &&
                ({1'b0, req_dy} < (OFS_W+1)'(IMG_H));
    active_d  = active_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    req_err_d = req_valid && !req_ok;
    if (frame_start) begin
      // A request landing on frame_start goes straight to the active set.
      if (req_ok) begin
        active_d = req_cfg;
      end else if (pending_q) begin
        active_d = pend_q;
      end
      pending_d = 1'b0;
    end else if (req_ok) begin
      pend_d    = req_cfg;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q  <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      req_err_q <= req_err_d;
    end
  end

  assign active  = active_q;
  assign req_err = req_err_q;

endmodule

// File: rtl/scaled_addr_gen.sv
// Raster-to-image address generator: power-of-two downscale, wrap-around
// scroll and optional mirror, through a two-stage registered pipeline.
module scaled_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned IMG_W       = IMG_W_DEF,
  parameter int unsigned IMG_H       = IMG_H_DEF,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              frame_start,
  input  logic              req_valid,
  input  logic [7:0]        req_dx,
  input  logic [7:0]        req_dy,
  input  logic              req_mirror,
  output logic              req_err,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              addr_valid
);

  scroll_cfg_t active;

  scroll_cfg_reg #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cfg (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .req_valid   (req_valid),
    .req_dx      (req_dx),
    .req_dy      (req_dy),
    .req_mirror  (req_mirror),
    .active      (active),
    .req_err     (req_err)
  );

  logic [SUM_W-1:0]  col;
  logic [SUM_W-1:0]  colw_d, colw_q;
  logic [SUM_W-1:0]  row_d, row_q;
  logic              vis_d, vis_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              valid_d, valid_q;

  // Stage 1: scaled, mirrored, scrolled image coordinates.
  always_comb begin
    col = SUM_W'(h_cnt >> SCALE_SHIFT);
    if (active.mirror) begin
      col = SUM_W'(IMG_W - 1) - col;
    end
    colw_d = wrap_add(col, SUM_W'(active.dx), SUM_W'(IMG_W));
    row_d  = wrap_add(SUM_W'(v_cnt >> SCALE_SHIFT), SUM_W'(active.dy), SUM_W'(IMG_H));
    vis_d  = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  end

  // Stage 2: linear address; constant multiplier reduces to shift-add.
  always_comb begin
    addr_d  = vis_q ? (ADDR_W'(row_q) * ADDR_W'(IMG_W) + ADDR_W'(colw_q)) : '0;
    valid_d = vis_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colw_q  <= '0;
      row_q   <= '0;
      vis_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      colw_q  <= colw_d;
      row_q   <= row_d;
      vis_q   <= vis_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign pixel_addr = addr_q;
  assign addr_valid = valid_q;

endmodule
